// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared states, funct3 codes and size helpers for the load/store unit
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Access size in bytes; the low two funct3 bits encode log2(size)
    function automatic logic [3:0] size_bytes(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 4'd1;
            2'b01:   return 4'd2;
            2'b10:   return 4'd4;
            default: return 4'd8;
        endcase
    endfunction

    // 111 is never valid; stores have no unsigned variants
    function automatic logic is_illegal(input logic we, input logic [2:0] f3);
        return (f3 == 3'b111) || (we && f3[2]);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - combinational load extraction/extension and store byte-lane merge
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  off,
    input  logic [2:0]  funct3,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic [63:0] merged
);

    logic [63:0] shifted;
    logic [63:0] lane_mask;
    logic [5:0]  sh;

    // Right-justify the addressed bytes, then sign- or zero-extend by funct3
    always_comb begin
        sh      = {off, 3'b000};
        shifted = word >> sh;
        case (funct3)
            F3_B:    rdata = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    rdata = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    rdata = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   rdata = {56'd0, shifted[7:0]};
            F3_HU:   rdata = {48'd0, shifted[15:0]};
            F3_WU:   rdata = {32'd0, shifted[31:0]};
            default: rdata = shifted;
        endcase
    end

    // Replace only the store's byte lanes; every other bit of the word passes through
    always_comb begin
        case (size_bytes(funct3))
            4'd1:    lane_mask = 64'h0000_0000_0000_00FF;
            4'd2:    lane_mask = 64'h0000_0000_0000_FFFF;
            4'd4:    lane_mask = 64'h0000_0000_FFFF_FFFF;
            default: lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
        endcase
        merged = (word & ~(lane_mask << sh)) | ((wdata & lane_mask) << sh);
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV64 load/store unit; LSU_MISALIGN_CHECK_EN turns misalignment into an error
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_WE,
    output logic [DATA_W-1:0] mem_dIn,
    input  logic [DATA_W-1:0] mem_dout
);

    lsu_state_t        state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [2:0]        off_q, off_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_din_q, mem_din_d;

    logic [3:0]        req_size;
    logic [2:0]        size_m1;
    logic              req_misaligned;
    logic              req_err;
    logic [2:0]        req_off;
    logic              accept;
    logic [DATA_W-1:0] align_rdata;
    logic [DATA_W-1:0] align_merged;

    assign req_ready   = (state_q == IDLE);
    assign resp_valid  = resp_valid_q;
    assign resp_err    = resp_err_q;
    assign resp_rdata  = resp_rdata_q;
    assign mem_address = mem_address_q;
    assign mem_WE      = mem_we_q;
    assign mem_dIn     = mem_din_q;

    // mem_dout is only meaningful in READ, where it feeds both the load and merge paths
    lsu_align u_align (
        .word   (mem_dout),
        .off    (off_q),
        .funct3 (f3_q),
        .wdata  (wdata_q),
        .rdata  (align_rdata),
        .merged (align_merged)
    );

    // Classify the incoming request: size, lane offset and error status
    always_comb begin
        accept         = req_valid && req_ready;
        req_size       = size_bytes(req_funct3);
        size_m1        = req_size[2:0] - 3'd1;
        req_misaligned = |(req_addr[2:0] & size_m1);
        req_off        = req_addr[2:0] & ~size_m1;
`ifdef LSU_MISALIGN_CHECK_EN
        req_err        = is_illegal(req_we, req_funct3) || req_misaligned;
`else
        req_err        = is_illegal(req_we, req_funct3);
`endif
    end

    // Next-state and next-output logic; every output is registered, mem_dIn doubles as the merge register
    always_comb begin
        state_d       = state_q;
        we_d          = we_q;
        f3_d          = f3_q;
        off_d         = off_q;
        wdata_d       = wdata_q;
        resp_valid_d  = 1'b0;
        resp_err_d    = resp_err_q;
        resp_rdata_d  = resp_rdata_q;
        mem_address_d = mem_address_q;
        mem_we_d      = 1'b0;
        mem_din_d     = mem_din_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    we_d         = req_we;
                    f3_d         = req_funct3;
                    off_d        = req_off;
                    wdata_d      = req_wdata;
                    resp_rdata_d = '0;
                    resp_err_d   = req_err;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                    end else begin
                        mem_address_d = {req_addr[ADDR_W-1:3], 3'b000};
                        if (req_we && req_size == 4'd8) begin
                            state_d   = WRITE;
                            mem_we_d  = 1'b1;
                            mem_din_d = req_wdata;
                        end else begin
                            state_d = READ;
                        end
                    end
                end
            end
            READ: begin
                if (we_q) begin
                    state_d   = WRITE;
                    mem_we_d  = 1'b1;
                    mem_din_d = align_merged;
                end else begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = align_rdata;
                end
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset abandons any access in flight
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            we_q          <= 1'b0;
            f3_q          <= 3'd0;
            off_q         <= 3'd0;
            wdata_q       <= '0;
            resp_valid_q  <= 1'b0;
            resp_err_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_address_q <= '0;
            mem_we_q      <= 1'b0;
            mem_din_q     <= '0;
        end else begin
            state_q       <= state_d;
            we_q          <= we_d;
            f3_q          <= f3_d;
            off_q         <= off_d;
            wdata_q       <= wdata_d;
            resp_valid_q  <= resp_valid_d;
            resp_err_q    <= resp_err_d;
            resp_rdata_q  <= resp_rdata_d;
            mem_address_q <= mem_address_d;
            mem_we_q      <= mem_we_d;
            mem_din_q     <= mem_din_d;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit against a byte-level memory model
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic [63:0] mem_address;
    logic        mem_WE;
    logic [63:0] mem_dIn;
    logic [63:0] mem_dout;

    logic [63:0] mem     [32];
    logic [63:0] ref_mem [32];
    logic        pl_en;
    logic [4:0]  pl_idx;
    logic [63:0] pl_val;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_address (mem_address),
        .mem_WE      (mem_WE),
        .mem_dIn     (mem_dIn),
        .mem_dout    (mem_dout)
    );

    assign mem_dout = mem[mem_address[7:3]];

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_idx] <= pl_val;
        else if (mem_WE)
            mem[mem_address[7:3]] <= mem_dIn;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: treat memory as bytes; pick/replace s bytes starting at the (possibly aligned) offset
    function automatic void model(input logic we, input logic [2:0] f3, input logic [7:0] addr,
                                  input logic [63:0] wdata, output int lat, output logic err,
                                  output logic [63:0] rdata, output int we_n, output int we_lat,
                                  output logic [63:0] new_word);
        int s;
        int off;
        logic [63:0] w;
        logic sgn;
        s        = 1 << f3[1:0];
        off      = int'(addr[2:0]);
        w        = ref_mem[addr[7:3]];
        err      = (f3 == 3'd7) || (we && f3 >= 3'd4);
`ifdef LSU_MISALIGN_CHECK_EN
        if (off % s != 0) err = 1'b1;
`else
        off = off - (off % s);
`endif
        rdata    = 64'd0;
        we_n     = 0;
        we_lat   = 0;
        new_word = w;
        lat      = 1;
        if (err) return;
        if (!we) begin
            lat = 2;
            sgn = (f3 < 3'd4) && (s < 8);
            for (int i = 0; i < 8; i++) begin
                if (i < s)
                    rdata[8*i +: 8] = w[8*(off+i) +: 8];
                else
                    rdata[8*i +: 8] = (sgn && w[8*(off+s-1)+7]) ? 8'hFF : 8'h00;
            end
        end else begin
            for (int i = 0; i < s; i++)
                new_word[8*(off+i) +: 8] = wdata[8*i +: 8];
            we_n   = 1;
            lat    = (s == 8) ? 2 : 3;
            we_lat = lat - 1;
        end
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [2:0] f3, input logic [7:0] addr,
                          input logic [63:0] wdata, output logic [63:0] obs_rdata, output logic [63:0] obs_din);
        int e_lat, e_we_n, e_we_lat;
        logic e_err;
        logic [63:0] e_rdata, e_word;
        int lat, wec, wl, t;
        logic got, o_err;
        model(we, f3, addr, wdata, e_lat, e_err, e_rdata, e_we_n, e_we_lat, e_word);
        t = 0;
        @(negedge clk);
        while (!req_ready && t < 10) begin
            @(negedge clk);
            t++;
        end
        check_val({tag, " ready"}, 64'(req_ready), 64'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = {56'd0, addr};
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; wec = 0; wl = 0; got = 1'b0; o_err = 1'b0;
        obs_rdata = 64'd0; obs_din = 64'd0;
        while (!got && lat < 8) begin
            @(negedge clk);
            lat++;
            if (mem_WE) begin
                wec++;
                wl = lat;
                obs_din = mem_dIn;
            end
            if (resp_valid) begin
                got = 1'b1;
                o_err = resp_err;
                obs_rdata = resp_rdata;
            end
        end
        check_val({tag, " latency"}, 64'(lat), 64'(e_lat));
        check_val({tag, " err"}, 64'(o_err), 64'(e_err));
        check_val({tag, " rdata"}, obs_rdata, e_rdata);
        check_val({tag, " we_cycles"}, 64'(wec), 64'(e_we_n));
        if (e_we_n != 0) begin
            check_val({tag, " we_lat"}, 64'(wl), 64'(e_we_lat));
            check_val({tag, " din"}, obs_din, e_word);
        end
        check_val({tag, " mem"}, mem[addr[7:3]], e_word);
        ref_mem[addr[7:3]] = e_word;
    endtask

    initial begin
        logic [63:0] rd, din;
        logic [63:0] v;
        logic        rwe;
        logic [2:0]  rf3;
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 64'd0;
        req_wdata  = 64'd0;
        pl_en      = 1'b1;
        pl_idx     = 5'd0;
        pl_val     = 64'd0;
        for (int i = 0; i < 32; i++) begin
            v = {$urandom, $urandom};
            if (i == 2) v = 64'h8877665544332211;
            ref_mem[i] = v;
            pl_idx = 5'(i);
            pl_val = v;
            @(negedge clk);
        end
        pl_en = 1'b0;

        check_val("rst ready", 64'(req_ready), 64'd1);
        check_val("rst resp_valid", 64'(resp_valid), 64'd0);
        check_val("rst resp_err", 64'(resp_err), 64'd0);
        check_val("rst resp_rdata", resp_rdata, 64'd0);
        check_val("rst mem_WE", 64'(mem_WE), 64'd0);
        check_val("rst mem_address", mem_address, 64'd0);
        check_val("rst mem_dIn", mem_dIn, 64'd0);
        reset = 1'b0;

        do_req("ld", 1'b0, 3'd3, 8'h10, 64'd0, rd, din);
        check_val("ld const", rd, 64'h8877665544332211);
        do_req("lb", 1'b0, 3'd0, 8'h17, 64'd0, rd, din);
        check_val("lb const", rd, 64'hFFFFFFFFFFFFFF88);
        do_req("lbu", 1'b0, 3'd4, 8'h17, 64'd0, rd, din);
        check_val("lbu const", rd, 64'h0000000000000088);
        do_req("sh", 1'b1, 3'd1, 8'h12, 64'h000000000000BEEF, rd, din);
        check_val("sh const", din, 64'h88776655BEEF2211);
        do_req("sd", 1'b1, 3'd3, 8'h20, 64'h0123456789ABCDEF, rd, din);
        check_val("sd const", din, 64'h0123456789ABCDEF);
        do_req("ill ld", 1'b0, 3'd7, 8'h08, 64'd0, rd, din);
        do_req("ill st", 1'b1, 3'd4, 8'h08, 64'h55, rd, din);
        do_req("lw mis", 1'b0, 3'd2, 8'h13, 64'd0, rd, din);
        do_req("sw mis", 1'b1, 3'd2, 8'h2E, 64'hCAFEF00D, rd, din);

        // Reset while a sub-word store sits in READ
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 64'h44;
        req_wdata  = 64'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_val("mid rst ready", 64'(req_ready), 64'd1);
        check_val("mid rst mem_WE", 64'(mem_WE), 64'd0);
        check_val("mid rst resp_valid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_val("mid rst mem_WE hold", 64'(mem_WE), 64'd0);
        reset = 1'b0;
        check_val("mid rst mem", mem[8], ref_mem[8]);
        do_req("post rst lw", 1'b0, 3'd2, 8'h44, 64'd0, rd, din);

        for (int n = 0; n < 300; n++) begin
            rwe = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            do_req("rand", rwe, rf3, 8'($urandom_range(0, 255)), {$urandom, $urandom}, rd, din);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the 64-bit data memory port: it drives address, write data and write enable, and samples the memory read data.
- Turns RV64 load/store requests (byte/half/word/double, signed/unsigned) into doubleword-aligned memory accesses.
- Sub-doubleword stores use a read-modify-write sequence.
- Sits between the execute stage and the memory block; instruction fetch is not handled here.

Parameters:
- ADDR_W, 64, width of the byte address and of mem_address.
- DATA_W, 64, memory word width; fixed at 64; other values are unsupported.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  a request is present.
- req_ready  output  1  unit accepts a request this cycle; high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RV64 size/sign code.
- req_addr  input  ADDR_W  byte address.
- req_wdata  input  DATA_W  store data, right-justified.
- resp_valid  output  1  one-cycle pulse; the response is complete.
- resp_rdata  output  DATA_W  load result, extended to 64 bits; 0 for stores and errors.
- resp_err  output  1  qualified by resp_valid; illegal or misaligned request.
- mem_address  output  ADDR_W  {addr[63:3],3'b000}.
- mem_WE  output  1  memory write enable, sampled by memory on rising clk.
- mem_dIn  output  DATA_W  data written to memory.
- mem_dout  input  DATA_W  combinational read data for mem_address.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0, mem_WE=0, mem_address=0, mem_dIn=0.
- Handshake: a request is accepted on a rising edge with req_valid&&req_ready. All request fields are latched at that edge. req_valid while not ready is ignored, not queued. There is no response backpressure.
- funct3 codes: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU; 111 is illegal.
  - Stores with funct3 in 100..111 are illegal.
  - Illegal requests: accepted edge leads to RESP with resp_err=1; no memory access.
- Offset off = addr[2:0]; size in bytes s = 1/2/4/8.
- States: IDLE, READ, WRITE, RESP, driven as follows.
  - IDLE: on accept, go to READ for loads and for stores with s<8, WRITE for s=8 stores, RESP for errors.
  - READ: mem_address driven; mem_dout captured into a merge register at the edge.
    - Load: goes to RESP. resp_rdata = (dout >> 8*off) truncated to s bytes, then sign-extended (B/H/W) or zero-extended (BU/HU/WU/D).
    - Store: goes to WRITE.
  - WRITE: mem_WE=1 for exactly this cycle. mem_dIn = captured word with bytes off..off+s-1 replaced by req_wdata[8s-1:0]; for s=8, mem_dIn = req_wdata. Goes to RESP.
  - RESP: resp_valid=1 for one cycle, then back to IDLE. req_ready returns to 1 in IDLE, so back-to-back requests are spaced by at least one idle cycle.
- Latency from the accept edge to the resp_valid cycle:
  - load: 2 cycles;
  - sub-word store: 3 cycles;
  - doubleword store: 2 cycles;
  - error: 1 cycle.
- mem_WE is 0 in every state except WRITE.
- Reset mid-operation: any state goes to IDLE. Reset asserted before the WRITE edge means no memory write occurs. An in-flight response is dropped.
- Bytes outside the store's lanes are preserved bit-exact.

Optional Feature:
- Macro: LSU_MISALIGN_CHECK_EN.
- Defined: off not a multiple of s sets resp_err=1 via IDLE→RESP, with no memory access.
- Undefined: misaligned addresses are force-aligned; off is masked to off & ~(s-1). No error is raised except for illegal funct3.

Decomposition:
- Package lsu_pkg holds:
  - the state enum (IDLE, READ, WRITE, RESP);
  - funct3 constants (F3_B..F3_WU);
  - a size-from-funct3 function.
- Sub-module lsu_align (purely combinational) does load extraction/extension and store merge. Inputs: word, off, funct3, wdata. Outputs: rdata, merged.

Test Plan:
- LD from address 0x10, memory word 0x8877665544332211: resp_valid 2 cycles after accept, resp_rdata=0x8877665544332211, mem_WE never high.
- LB at 0x17 on the same word: resp_rdata=0xFFFFFFFFFFFFFF88. LBU at 0x17: 0x0000000000000088.
- SH 0xBEEF at 0x12 over 0x8877665544332211: single WE cycle with mem_dIn=0x88776655BEEF2211, resp_err=0.
- SD 0x0123456789ABCDEF at 0x20: no READ state, WE one cycle after accept, response 2 cycles after accept.
- Illegal funct3=111 load, and with LSU_MISALIGN_CHECK_EN, LW at 0x13: resp_err=1 next cycle, mem_WE stays 0.
- Assert reset during READ of an SW: state IDLE immediately, no write, the memory word is unchanged; a new request is accepted after reset deasserts.
